mem_arbiter: RTL and testbench

Two-port arbiter that shares the single four-banked main memory between the instruction-cache controller (read-only port I) and the data-cache controller (read/write port D). It latches one request at a time, waits for the target bank to be free, issues a single memory access, collects read data and error, and returns a one-cycle acknowledge to the winning requester. It sits between the two cache controllers and the banked memory and owns all memory `mem_rd`/`mem_wr` strobes.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (I read-only, D read/write) arbiter in front of a four-banked memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed D-over-I priority instead of round-robin.
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    input  logic [3:0]    mem_busy,
    input  logic          mem_stall,
    input  logic          mem_err,
    output logic          arb_busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, RD1, RD2, ACK} state_t;

    state_t        state_q, state_d;
    logic          own_d_q, own_d_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          err_acc_q, err_acc_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          i_err_q, i_err_d;
    logic          d_err_q, d_err_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          arb_busy_q, arb_busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic          last_d_q, last_d_d;
`endif

    logic [1:0] bank;
    logic       issue_ok;
    logic       grant_d;
    logic       err_next;

    assign bank     = addr_q[2:1];
    assign issue_ok = (state_q == ISSUE) && !mem_busy[bank] && !mem_stall;
    // Strobes follow the same-cycle bank/stall status, so they cannot be registered.
    assign mem_rd   = issue_ok && !wr_q;
    assign mem_wr   = issue_ok && wr_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign grant_d = d_req;
`else
    assign grant_d = d_req && (!i_req || !last_d_q);
`endif

    assign err_next = err_acc_q |
                      (mem_err && (issue_ok || state_q == RD1 || state_q == RD2));

    always_comb begin
        state_d   = state_q;
        own_d_d   = own_d_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_acc_d = err_acc_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d_d  = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    own_d_d   = grant_d;
                    wr_d      = grant_d && d_wr;
                    addr_d    = grant_d ? d_addr : i_addr;
                    wdata_d   = grant_d ? d_wdata : '0;
                    err_acc_d = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ok) begin
                    err_acc_d = err_next;
                    state_d   = wr_q ? ACK : RD1;
                end
            end
            RD1: begin
                err_acc_d = err_next;
                state_d   = RD2;
            end
            RD2: begin
                err_acc_d = err_next;
                if (own_d_q) begin
                    d_rdata_d = mem_rdata;
                end else begin
                    i_rdata_d = mem_rdata;
                end
                state_d = ACK;
            end
            ACK: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                last_d_d = own_d_q;
`endif
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Acks are registered: they are set on the transition into ACK.
        if (state_q != ACK && state_d == ACK) begin
            i_ack_d = !own_d_q;
            d_ack_d = own_d_q;
            i_err_d = !own_d_q && err_next;
            d_err_d = own_d_q && err_next;
        end
        arb_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            own_d_q    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_acc_q  <= 1'b0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            arb_busy_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_d_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            own_d_q    <= own_d_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_acc_q  <= err_acc_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            i_err_q    <= i_err_d;
            d_err_q    <= d_err_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            arb_busy_q <= arb_busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_d_q   <= last_d_d;
`endif
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_err     = i_err_q;
    assign d_err     = d_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model of grant/issue/ack timing. Honours MEM_ARB_FIXED_PRIO_EN.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [3:0]    mem_busy = '0;
    logic          mem_stall = 1'b0, mem_err = 1'b0;
    logic          i_ack, i_err, d_ack, d_err, mem_rd, mem_wr, arb_busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_stall(mem_stall),
        .mem_err(mem_err), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    // Values staged between cycles and applied just after the next rising edge.
    logic          s_rst = 1'b0, s_i_req = 1'b1, s_d_req = 1'b1, s_d_wr = 1'b0;
    logic [AW-1:0] s_i_addr = 16'h0008, s_d_addr = 16'h000A;
    logic [DW-1:0] s_d_wdata = '0;
    logic [3:0]    s_busy = '0;
    logic          s_stall = 1'b0, s_err = 1'b0;
    bit            i_keep = 1'b0, d_keep = 1'b0, rand_mode = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int last_wr = -1;

    typedef struct { bit d; int cyc; logic [15:0] rdata; bit err; } ack_t;
    typedef struct { int due; logic [15:0] data; } rsp_t;
    ack_t acklog[$];
    rsp_t rsp_q[$];

    logic [15:0] dev_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    bit          m_have = 1'b0, m_issued, m_d, m_wr, m_err, m_last_d = 1'b1;
    logic [15:0] m_addr, m_wdata, m_rdata, m_irdata = '0, m_drdata = '0;
    int          m_grant, m_ack;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_init(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] dev_rd(input logic [15:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return mem_init(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_init(a);
    endfunction

    // One grant at a time; it issues on the first later cycle whose bank is free and
    // unstalled, and acks 1 (write) or 3 (read) cycles after issue.
    task automatic model_step();
        bit e_rd, e_wr, e_iack, e_dack, e_busy;
        e_rd = 1'b0; e_wr = 1'b0; e_iack = 1'b0; e_dack = 1'b0;
        if (!rst) begin
            check("rst_ctrl", 64'({i_ack, d_ack, i_err, d_err, mem_rd, mem_wr, arb_busy}), 64'd0);
            check("rst_data", {mem_addr, mem_wdata, i_rdata, d_rdata}, 64'd0);
            m_have = 1'b0; m_last_d = 1'b1; m_irdata = '0; m_drdata = '0;
            return;
        end
        e_busy = m_have && (cyc > m_grant);
        if (e_busy) begin
            check("mem_addr", 64'(mem_addr), 64'(m_addr));
            if (!m_issued) begin
                if (!mem_busy[m_addr[2:1]] && !mem_stall) begin
                    m_issued = 1'b1;
                    m_err    = mem_err;
                    m_ack    = cyc + (m_wr ? 1 : 3);
                    if (m_wr) begin
                        e_wr = 1'b1;
                        check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
                        ref_mem[m_addr] = m_wdata;
                    end else begin
                        e_rd = 1'b1;
                        m_rdata = ref_rd(m_addr);
                    end
                end
            end else if (cyc < m_ack) begin
                m_err = m_err | mem_err;
            end
            if (m_issued && cyc == m_ack) begin
                if (m_d) begin
                    e_dack = 1'b1;
                    if (!m_wr) m_drdata = m_rdata;
                    check("d_err", 64'(d_err), 64'(m_err));
                end else begin
                    e_iack = 1'b1;
                    m_irdata = m_rdata;
                    check("i_err", 64'(i_err), 64'(m_err));
                end
            end
        end else if (!m_have && (i_req || d_req)) begin
            m_d      = FIXED ? d_req : (d_req && (!i_req || !m_last_d));
            m_wr     = m_d && d_wr;
            m_addr   = m_d ? d_addr : i_addr;
            m_wdata  = d_wdata;
            m_have   = 1'b1;
            m_issued = 1'b0;
            m_grant  = cyc;
        end
        check("mem_rd", 64'(mem_rd), 64'(e_rd));
        check("mem_wr", 64'(mem_wr), 64'(e_wr));
        check("i_ack", 64'(i_ack), 64'(e_iack));
        check("d_ack", 64'(d_ack), 64'(e_dack));
        check("arb_busy", 64'(arb_busy), 64'(e_busy));
        check("i_rdata", 64'(i_rdata), 64'(m_irdata));
        check("d_rdata", 64'(d_rdata), 64'(m_drdata));
        if (e_iack || e_dack) begin
            m_last_d = m_d;
            m_have   = 1'b0;
        end
    endtask

    task automatic step();
        ack_t a;
        rsp_t r;
        @(posedge clk);
        #1;
        cyc++;
        rst = s_rst; i_req = s_i_req; i_addr = s_i_addr;
        d_req = s_d_req; d_wr = s_d_wr; d_addr = s_d_addr; d_wdata = s_d_wdata;
        mem_busy = s_busy; mem_stall = s_stall; mem_err = s_err;
        mem_rdata = 16'($urandom);
        while (rsp_q.size() > 0 && rsp_q[0].due < cyc) rsp_q.delete(0);
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) mem_rdata = rsp_q[0].data;
        @(negedge clk);
        if (rst) begin
            if (i_ack) begin a.d = 1'b0; a.cyc = cyc; a.rdata = i_rdata; a.err = i_err; acklog.push_back(a); end
            if (d_ack) begin a.d = 1'b1; a.cyc = cyc; a.rdata = d_rdata; a.err = d_err; acklog.push_back(a); end
            if (mem_rd) begin
                rd_cnt++;
                r.due = cyc + 2; r.data = dev_rd(mem_addr);
                rsp_q.push_back(r);
            end
            if (mem_wr) begin
                last_wr = cyc;
                dev_mem[mem_addr] = mem_wdata;
            end
        end
        model_step();
        if (i_req && i_ack) s_i_req = i_keep;
        else if (rand_mode && !s_i_req && $urandom_range(0, 3) == 0) begin
            s_i_req = 1'b1; s_i_addr = 16'($urandom_range(0, 31));
        end
        if (d_req && d_ack) s_d_req = d_keep;
        else if (rand_mode && !s_d_req && $urandom_range(0, 3) == 0) begin
            s_d_req = 1'b1; s_d_wr = 1'($urandom_range(0, 1));
            s_d_addr = 16'($urandom_range(0, 31)); s_d_wdata = 16'($urandom);
        end
        if (rand_mode) begin
            s_busy  = 4'($urandom) & 4'($urandom);
            s_stall = ($urandom_range(0, 4) == 0);
            s_err   = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic wait_ack(output int ac);
        int n0;
        n0 = acklog.size();
        ac = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (acklog.size() > n0) begin
                ac = cyc;
                return;
            end
        end
        check("ack_seen", 64'(acklog.size() > n0), 64'd1);
    endtask

    task automatic drain();
        i_keep = 1'b0; d_keep = 1'b0;
        s_busy = '0; s_stall = 1'b0; s_err = 1'b0;
        for (int i = 0; i < 60 && (s_i_req || s_d_req || m_have || i_req || d_req); i++) step();
        s_i_req = 1'b0; s_d_req = 1'b0;
        step(); step();
    endtask

    initial begin
        int k, ac, n0;

        // Reset held with both requests pending; tie after reset goes to I (D if fixed).
        repeat (3) step();
        s_rst = 1'b1;
        n0 = acklog.size();
        wait_ack(ac);
        if (acklog.size() > n0) check("first_grant_d", 64'(acklog[n0].d), 64'(FIXED));
        drain();

        // Plain D read.
        ref_mem[16'h0014] = 16'hBEEF;
        dev_mem[16'h0014] = 16'hBEEF;
        s_d_req = 1'b1; s_d_wr = 1'b0; s_d_addr = 16'h0014;
        rd_cnt = 0;
        step(); k = cyc;
        wait_ack(ac);
        if (ac >= 0) begin
            check("rd_latency", 64'(ac - k), 64'd4);
            check("rd_owner_d", 64'(acklog[$].d), 64'd1);
            check("rd_data", 64'(acklog[$].rdata), 64'(16'hBEEF));
            check("rd_err", 64'(acklog[$].err), 64'd0);
            check("rd_strobes", 64'(rd_cnt), 64'd1);
        end
        drain();

        // Write to bank 1 while bank 1 is busy for three cycles.
        s_d_req = 1'b1; s_d_wr = 1'b1; s_d_addr = 16'h0002; s_d_wdata = 16'h1234;
        step(); k = cyc;
        s_busy = 4'b0010;
        repeat (3) step();
        s_busy = '0;
        wait_ack(ac);
        if (ac >= 0) begin
            check("conf_latency", 64'(ac - k), 64'd5);
            check("conf_wr_cycle", 64'(last_wr - k), 64'd4);
        end
        drain();

        // Fairness with both requests held.
        i_keep = 1'b1; d_keep = 1'b1;
        s_i_req = 1'b1; s_i_addr = 16'h0020;
        s_d_req = 1'b1; s_d_wr = 1'b0; s_d_addr = 16'h0030;
        n0 = acklog.size();
        for (int i = 0; i < 4; i++) wait_ack(ac);
        for (int i = 0; i < 4; i++)
            if (acklog.size() > n0 + i)
                check($sformatf("fair%0d", i), 64'(acklog[n0 + i].d), 64'(FIXED ? 1 : (i % 2)));
        drain();

        // Error pulsed in RD1 of an I read; the following access is clean.
        s_i_req = 1'b1; s_i_addr = 16'h0040;
        step(); k = cyc;
        step();
        s_err = 1'b1;
        step();
        s_err = 1'b0;
        wait_ack(ac);
        if (ac >= 0) begin
            check("err_latency", 64'(ac - k), 64'd4);
            check("err_owner_d", 64'(acklog[$].d), 64'd0);
            check("err_flag", 64'(acklog[$].err), 64'd1);
        end
        drain();
        s_i_req = 1'b1; s_i_addr = 16'h0040;
        wait_ack(ac);
        if (ac >= 0) check("err_cleared", 64'(acklog[$].err), 64'd0);
        drain();

        // Reset asserted during RD1 abandons the read.
        s_d_req = 1'b1; s_d_wr = 1'b0; s_d_addr = 16'h0014;
        step(); k = cyc;
        step();
        s_rst = 1'b0; s_d_req = 1'b0;
        step();
        s_rst = 1'b1;
        n0 = acklog.size();
        repeat (6) step();
        check("no_ack_after_rst", 64'(acklog.size() - n0), 64'd0);
        check("idle_after_rst", 64'(arb_busy), 64'd0);
        s_d_req = 1'b1; s_d_wr = 1'b0; s_d_addr = 16'h0014;
        step(); k = cyc;
        wait_ack(ac);
        if (ac >= 0) begin
            check("post_rst_latency", 64'(ac - k), 64'd4);
            check("post_rst_data", 64'(acklog[$].rdata), 64'(16'hBEEF));
        end
        drain();

        // Random traffic with random bank busy, stalls and errors.
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
